puf_response_reader: RTL and testbench



---
 rtl/puf_response_reader.sv | 162 ++++++++++++++++
 tb/tb_puf_response_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_reader.sv
// PUF readout sequencer: repeated reset/START evaluations per cell, majority vote, ID assembly.
// Latency: done NUM_CELLS*(VOTES*(SETTLE+3)+1) cycles after the cycle that follows an accepted go.
// Backpressure: none; go is only accepted in IDLE and ignored while busy (including the DONE cycle).
module puf_response_reader #(
    parameter int NUM_CELLS = 8,
    parameter int VOTES     = 7,
    parameter int SETTLE    = 15,
    localparam int SEL_W    = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    output logic                 busy,
    output logic                 done,
    output logic                 id_valid,
    output logic [NUM_CELLS-1:0] id_out,
    output logic [NUM_CELLS-1:0] unstable_mask,
    output logic [SEL_W-1:0]     puf_sel,
    output logic                 puf_reset,
    output logic                 puf_start,
    input  logic                 puf_out
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam int VW    = $clog2(VOTES + 1);

    localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [VW-1:0]    VOTE_LAST = VW'(VOTES - 1);
    localparam logic [VW-1:0]    MAJ       = VW'(VOTES / 2);
    localparam logic [VW-1:0]    ALL_ONES  = VW'(VOTES);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_CELLS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRST   = 3'd1,
        RUN    = 3'd2,
        SAMPLE = 3'd3,
        VOTE   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t               state, state_d;
    logic                 sync_d1, sync_q;
    logic [CNT_W-1:0]     cnt;
    logic [VW-1:0]        votes, ones;
    logic [SEL_W-1:0]     sel;
    logic [NUM_CELLS-1:0] id_q, mask_q;
    logic                 id_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        busy      = 1'b1;
        done      = 1'b0;
        puf_reset = 1'b1;
        puf_start = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (go) state_d = PRST;
            end
            PRST: begin
                if (cnt == PRST_LAST) state_d = RUN;
            end
            RUN: begin
                puf_reset = 1'b0;
                puf_start = 1'b1;
                if (cnt == RUN_LAST) state_d = SAMPLE;
            end
            SAMPLE: begin
                state_d = (votes == VOTE_LAST) ? VOTE : PRST;
            end
            VOTE: begin
                state_d = (sel == SEL_LAST) ? DONE : PRST;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_d1    <= 1'b0;
            sync_q     <= 1'b0;
            cnt        <= '0;
            votes      <= '0;
            ones       <= '0;
            sel        <= '0;
            id_q       <= '0;
            mask_q     <= '0;
            id_valid_q <= 1'b0;
        end else begin
            sync_d1 <= puf_out;
            sync_q  <= sync_d1;

            // Phase counter restarts on every state change, so PRST and RUN both count from 0.
            if (state_d != state || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (go) begin
                        id_q       <= '0;
                        mask_q     <= '0;
                        id_valid_q <= 1'b0;
                        sel        <= '0;
                        ones       <= '0;
                        votes      <= '0;
                    end
                end
                SAMPLE: begin
                    ones  <= ones + VW'(sync_q);
                    votes <= votes + VW'(1);
                end
                VOTE: begin
                    for (int i = 0; i < NUM_CELLS; i++) begin
                        if (sel == SEL_W'(i)) begin
                            id_q[i]   <= (ones > MAJ);
                            mask_q[i] <= (ones != '0) && (ones != ALL_ONES);
                        end
                    end
                    ones  <= '0;
                    votes <= '0;
                    if (sel == SEL_LAST) begin
                        id_valid_q <= 1'b1;
                    end else begin
                        sel <= sel + SEL_W'(1);
                    end
                end
                DONE: begin
                    sel <= '0;
                end
                default: ;
            endcase
        end
    end

    assign id_out        = id_q;
    assign unstable_mask = mask_q;
    assign id_valid      = id_valid_q;
    assign puf_sel       = sel;

    a_start_reset_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(puf_start && puf_reset));
    a_done_single_cycle: assert property (@(posedge clk) disable iff (reset)
        done |=> !done);

endmodule

// File: tb/tb_puf_response_reader.sv
// Bench for puf_response_reader: vector table of PUF behaviours, scoreboard of expected IDs,
// plus hand sequences for ignored go, mid-run reset and a minimal single-cell configuration.
module tb_puf_response_reader;

    localparam int NC  = 8;
    localparam int NV  = 7;
    localparam int ST  = 15;
    localparam int LAT = NC * (NV * (ST + 3) + 1);
    localparam int LAT_S = 1 * (1 * (2 + 3) + 1);

    typedef logic [NC-1:0][NV-1:0] bits_t;

    typedef struct {
        bits_t           bits;
        logic [NC-1:0]   exp_id;
        logic [NC-1:0]   exp_mask;
    } vec_t;

    typedef struct {
        logic [NC-1:0] id;
        logic [NC-1:0] mask;
        int            done_edge;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic          busy, done, id_valid;
    logic [NC-1:0] id_out, unstable_mask;
    logic [2:0]    puf_sel;
    logic          puf_reset, puf_start, puf_out;

    logic          s_go = 1'b0;
    logic          s_busy, s_done, s_id_valid;
    logic [0:0]    s_id, s_mask, s_sel;
    logic          s_prst, s_start;
    logic          s_out = 1'b0;

    puf_response_reader #(.NUM_CELLS(NC), .VOTES(NV), .SETTLE(ST)) dut (
        .clk(clk), .reset(reset), .go(go), .busy(busy), .done(done), .id_valid(id_valid),
        .id_out(id_out), .unstable_mask(unstable_mask), .puf_sel(puf_sel),
        .puf_reset(puf_reset), .puf_start(puf_start), .puf_out(puf_out)
    );

    puf_response_reader #(.NUM_CELLS(1), .VOTES(1), .SETTLE(2)) dut_s (
        .clk(clk), .reset(reset), .go(s_go), .busy(s_busy), .done(s_done), .id_valid(s_id_valid),
        .id_out(s_id), .unstable_mask(s_mask), .puf_sel(s_sel),
        .puf_reset(s_prst), .puf_start(s_start), .puf_out(s_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PUF model: each cell returns bits[cell][evaluation], evaluation advancing after each SAMPLE.
    bits_t model_bits = '0;
    int    ev = 0;
    logic  start_prev = 1'b0;
    always @(posedge clk) begin
        start_prev <= puf_start;
        if (busy === 1'b0) ev <= 0;
        else if (start_prev === 1'b1 && puf_start === 1'b0) ev <= (ev == NV - 1) ? 0 : ev + 1;
    end
    assign puf_out = model_bits[puf_sel][ev];

    int checks = 0;
    int fails  = 0;
    int runs_done = 0;
    bit mon_skip = 1'b0;
    exp_t sbq[$];

    int         viol = 0, done_cnt = 0, st_len = 0, rs_len = 0;
    logic       done_prev = 1'b0, s_done_prev = 1'b0, busy_prev = 1'b0;
    logic [2:0] sel_prev = '0;
    always @(negedge clk) begin
        int v;
        v = 0;
        if (puf_start === 1'b1 && puf_reset === 1'b1) v++;
        if (s_start === 1'b1 && s_prst === 1'b1) v++;
        if (done === 1'b1 && done_prev === 1'b1) v++;
        if (s_done === 1'b1 && s_done_prev === 1'b1) v++;
        if (busy === 1'b0 && puf_sel !== 3'd0) v++;
        if (mon_skip) begin
            st_len <= 0;
            rs_len <= 0;
        end else if (puf_start === 1'b1) begin
            if (st_len == 0 && rs_len < 2) v++;
            st_len <= st_len + 1;
            rs_len <= 0;
        end else begin
            if (st_len != 0 && st_len != ST) v++;
            st_len <= 0;
            if (puf_reset === 1'b1) rs_len <= rs_len + 1;
        end
        if (!mon_skip && busy === 1'b1 && busy_prev === 1'b1 &&
            puf_sel !== sel_prev && puf_sel !== sel_prev + 3'd1) v++;
        if (!mon_skip && busy === 1'b1 && busy_prev === 1'b0 && puf_sel !== 3'd0) v++;
        viol <= viol + v;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        done_prev   <= done;
        s_done_prev <= s_done;
        busy_prev   <= busy;
        sel_prev    <= puf_sel;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bits_t static_bits(input logic [NC-1:0] p);
        bits_t b;
        for (int c = 0; c < NC; c++) b[c] = p[c] ? {NV{1'b1}} : {NV{1'b0}};
        return b;
    endfunction

    task automatic start_run(input string tag, input bits_t b, input logic [NC-1:0] eid,
                             input logic [NC-1:0] em, input bit push, output int ge);
        @(negedge clk);
        model_bits = b;
        go = 1'b1;
        ge = cyc + 1;
        @(negedge clk);
        go = 1'b0;
        if (push) sbq.push_back('{id: eid, mask: em, done_edge: ge + LAT});
        chk({tag, "_busy_after_go"}, busy, 1);
        chk({tag, "_valid_cleared"}, id_valid, 0);
        chk({tag, "_id_cleared"}, id_out, 0);
    endtask

    task automatic finish_run(input string tag, input bit go_in_done);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < LAT + 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, done, 1);
        if (sbq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
            return;
        end
        e = sbq.pop_front();
        if (done === 1'b1) begin
            runs_done++;
            chk({tag, "_done_cycle"}, cyc, e.done_edge);
            chk({tag, "_id"}, id_out, e.id);
            chk({tag, "_mask"}, unstable_mask, e.mask);
            chk({tag, "_valid_at_done"}, id_valid, 1);
        end
        if (go_in_done) go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_done_width"}, done, 0);
        repeat (4) @(negedge clk);
        chk({tag, "_valid_hold"}, id_valid, 1);
        chk({tag, "_idle_stays"}, busy, 0);
        chk({tag, "_id_hold"}, id_out, e.id);
    endtask

    task automatic small_run(input logic v);
        int ge, n;
        @(negedge clk);
        s_out = v;
        s_go = 1'b1;
        ge = cyc + 1;
        @(negedge clk);
        s_go = 1'b0;
        n = 0;
        while (s_done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("small_done_seen", s_done, 1);
        chk("small_done_cycle", cyc, ge + LAT_S);
        chk("small_id", s_id, v);
        chk("small_mask", s_mask, 0);
        chk("small_valid", s_id_valid, 1);
    endtask

    vec_t tbl[5];

    initial begin
        bits_t b;
        int    ge, dc0;

        tbl[0] = '{static_bits(8'hFF), 8'hFF, 8'h00};
        tbl[1] = '{static_bits(8'hA5), 8'hA5, 8'h00};
        b = static_bits(8'h3C);
        b[3] = 7'b0101011;
        b[5] = 7'b1000101;
        tbl[2] = '{b, 8'h1C, 8'h28};
        tbl[3] = '{static_bits(8'h00), 8'h00, 8'h00};
        b = static_bits(8'h00);
        b[0] = 7'b1111110;
        b[7] = 7'b0010000;
        tbl[4] = '{b, 8'h01, 8'h81};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", id_valid, 0);
        chk("rst_id", id_out, 0);
        chk("rst_mask", unstable_mask, 0);
        chk("rst_sel", puf_sel, 0);
        chk("rst_puf_reset", puf_reset, 1);
        chk("rst_puf_start", puf_start, 0);
        chk("rst_sync", {dut.sync_d1, dut.sync_q}, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            start_run($sformatf("vec%0d", i), tbl[i].bits, tbl[i].exp_id, tbl[i].exp_mask, 1'b1, ge);
            finish_run($sformatf("vec%0d", i), 1'b0);
        end

        // go pulses while busy and in the DONE cycle must all be ignored.
        start_run("busygo", static_bits(8'h5A), 8'h5A, 8'h00, 1'b1, ge);
        repeat (190) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (399) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        finish_run("busygo", 1'b1);

        // Synchronous reset in the middle of cell 3.
        dc0 = done_cnt;
        start_run("midrst", static_bits(8'hFF), 8'hFF, 8'h00, 1'b0, ge);
        repeat (499) @(negedge clk);
        chk("midrst_partial_id", id_out, 8'h07);
        chk("midrst_busy_before", busy, 1);
        mon_skip = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_puf_reset", puf_reset, 1);
        chk("midrst_puf_start", puf_start, 0);
        chk("midrst_id", id_out, 0);
        chk("midrst_mask", unstable_mask, 0);
        chk("midrst_valid", id_valid, 0);
        chk("midrst_sel", puf_sel, 0);
        repeat (30) @(negedge clk);
        mon_skip = 1'b0;
        chk("midrst_no_done", done_cnt, dc0);
        chk("midrst_still_idle", busy, 0);
        start_run("postrst", static_bits(8'hC3), 8'hC3, 8'h00, 1'b1, ge);
        finish_run("postrst", 1'b0);

        small_run(1'b1);
        small_run(1'b0);

        repeat (3) @(negedge clk);
        chk("invariants", viol, 0);
        chk("done_pulses", done_cnt, runs_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "bench timeout");
    end

endmodule
